// File: rtl/control_hazard_unit.sv
// control_hazard_unit
//   Injects decode-stage bubbles after jumps (JAL/JALR) and taken conditional
//   branches, and counts the redirect events.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     opcode          decode-stage opcode (7 bits)
//     id_valid        decode holds a valid instruction
//     stall           load-use freeze; state and counters hold
//     br_resolved     EX resolves the pending branch this cycle
//     br_taken        resolved branch is taken (qualified by br_resolved)
//     flush           external redirect; returns to IDLE and kills the bubble
//     nop_inject      replace decode output with a NOP this cycle
//     busy            FSM is not IDLE
//     bubbles_left    remaining flush cycles (0 in IDLE/BWAIT)
//     event_cnt       saturating count of injected redirect events
module control_hazard_unit #(
  parameter int unsigned JUMP_BUBBLES   = 1,
  parameter int unsigned BRANCH_BUBBLES = 2,
  parameter bit          BRANCH_EN      = 1'b1,
  parameter int unsigned STAT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              br_resolved,
  input  logic              br_taken,
  input  logic              flush,
  output logic              nop_inject,
  output logic              busy,
  output logic [3:0]        bubbles_left,
  output logic [STAT_W-1:0] event_cnt
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] JB_RELOAD = 4'(JUMP_BUBBLES - 1);
  localparam logic [3:0] BB_RELOAD = 4'(BRANCH_BUBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    JFLUSH,
    BWAIT,
    BFLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        bubbles_q, bubbles_d;
  logic [STAT_W-1:0] event_cnt_q, event_cnt_d;
  logic              cnt_inc;
  logic              jump_hit;
  logic              br_hit;

  assign jump_hit = id_valid && !stall && (opcode == OP_JAL || opcode == OP_JALR);
  assign br_hit   = BRANCH_EN && id_valid && !stall && (opcode == OP_BRANCH);

  always_comb begin
    state_d    = state_q;
    bubbles_d  = bubbles_q;
    nop_inject = 1'b0;
    cnt_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (jump_hit) begin
          nop_inject = 1'b1;
          cnt_inc    = 1'b1;
          if (JUMP_BUBBLES > 1) begin
            state_d   = JFLUSH;
            bubbles_d = JB_RELOAD;
          end
        end else if (br_hit) begin
          state_d = BWAIT;
        end
      end
      BWAIT: begin
        nop_inject = 1'b1;
        if (!stall && br_resolved) begin
          if (br_taken) begin
            cnt_inc = 1'b1;
            if (BRANCH_BUBBLES > 1) begin
              state_d   = BFLUSH;
              bubbles_d = BB_RELOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      JFLUSH, BFLUSH: begin
        nop_inject = 1'b1;
        if (!stall) begin
          bubbles_d = bubbles_q - 4'd1;
          if (bubbles_q == 4'd1) state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        bubbles_d = '0;
      end
    endcase

    // Flush overrides everything decided above, including the event count.
    if (flush) begin
      state_d    = IDLE;
      bubbles_d  = '0;
      nop_inject = 1'b0;
      cnt_inc    = 1'b0;
    end

    event_cnt_d = event_cnt_q;
    if (cnt_inc && event_cnt_q != '1) event_cnt_d = event_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bubbles_q   <= '0;
      event_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bubbles_q   <= bubbles_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign bubbles_left = bubbles_q;
  assign event_cnt    = event_cnt_q;

endmodule
